// File: rtl/d_flip_flop_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : d_flip_flop_pipe_if
//  Description : Bundle of the data, control and status signals of the
//                d_flip_flop_pipe delay line. The master side drives data and
//                control. The slave side (the pipeline) returns the stage
//                contents and the fill status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface d_flip_flop_pipe_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     srst;   // synchronous reset, active-high
    logic                     ena;    // shift enable
    logic [WIDTH-1:0]         d;      // data into stage 0
    logic [WIDTH-1:0]         q;      // last stage
    logic [WIDTH*DEPTH-1:0]   taps;   // all stages, stage 0 in the low bits
    logic [CW-1:0]            fill;   // stages written since reset
    logic                     full;   // fill == DEPTH

    modport master (
        output srst, ena, d,
        input  q, taps, fill, full
    );

    modport slave (
        input  srst, ena, d,
        output q, taps, fill, full
    );
endinterface
`default_nettype wire

// File: rtl/d_flip_flop_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : d_flip_flop_pipe
//  Description : DEPTH-stage, WIDTH-bit enabled delay line with asynchronous
//                (active-low) and synchronous (active-high) reset. The reset
//                value is configurable. A saturating fill counter and a full
//                flag report how many stages hold data written since the
//                last reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_flip_flop_pipe #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic            clk,
    input  wire logic            arst,
    d_flip_flop_pipe_if.slave    pipe
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

    // Reject unsupported depths at elaboration time.
    if (DEPTH < 1 || DEPTH > 64) begin : g_depth_check
        $error("d_flip_flop_pipe: DEPTH must be in 1..64");
    end

    logic [WIDTH*DEPTH-1:0] stages_q;
    logic [WIDTH*DEPTH-1:0] stages_d;
    logic [WIDTH*DEPTH-1:0] stages_shift;
    logic [CW-1:0]          fill_q;
    logic [CW-1:0]          fill_d;

    // Shifted image of the bank: new data enters at stage 0 and the oldest
    // stage drops off the top.
    if (DEPTH == 1) begin : g_shift_single
        assign stages_shift = pipe.d;
    end else begin : g_shift_chain
        assign stages_shift = {stages_q[WIDTH*(DEPTH-1)-1:0], pipe.d};
    end

    // Next state: synchronous reset beats enable, and enable beats hold.
    always_comb begin
        stages_d = stages_q;
        fill_d   = fill_q;
        if (pipe.srst) begin
            stages_d = {DEPTH{RST_VAL}};
            fill_d   = '0;
        end else if (pipe.ena) begin
            stages_d = stages_shift;
            fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + CW'(1);
        end
    end

    // State registers. The asynchronous reset dominates everything.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            stages_q <= {DEPTH{RST_VAL}};
            fill_q   <= '0;
        end else begin
            stages_q <= stages_d;
            fill_q   <= fill_d;
        end
    end

    // All outputs come straight from registers. full is a pure decode of
    // fill_q, so it rises on the same edge that fill reaches DEPTH.
    assign pipe.taps = stages_q;
    assign pipe.q    = stages_q[(DEPTH-1)*WIDTH +: WIDTH];
    assign pipe.fill = fill_q;
    assign pipe.full = (fill_q == FILL_MAX);

endmodule
`default_nettype wire
